// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings, FSM state type and helper functions for the decode-stage branch resolver.
// Wait figures count the decode cycles until a producer's result can be bypassed.
package branch_resolve_unit_pkg;

   localparam logic [2:0] FunctBeq  = 3'b000;
   localparam logic [2:0] FunctBne  = 3'b001;
   localparam logic [2:0] FunctBlt  = 3'b100;
   localparam logic [2:0] FunctBge  = 3'b101;
   localparam logic [2:0] FunctBltu = 3'b110;
   localparam logic [2:0] FunctBgeu = 3'b111;

   typedef enum logic [0:0] {
      StEval,
      StWait
   } state_e;

   localparam logic [1:0] BhtReset = 2'b01;

   typedef logic [1:0] wait_t;

   localparam wait_t WaitNone    = 2'd0;
   localparam wait_t WaitExAlu   = 2'd1;
   localparam wait_t WaitExLoad  = 2'd2;
   localparam wait_t WaitMemLoad = 2'd1;

   function automatic logic producer_hit(logic [4:0] rd, logic wen, logic [4:0] src);
      return wen && (rd != 5'd0) && (rd == src);
   endfunction

   // EX outranks MEM; an ALU result already in MEM is bypassed without waiting.
   function automatic wait_t operand_wait(logic ex_hit, logic ex_load, logic mem_hit,
                                          logic mem_load);
      if (ex_hit) begin
         return ex_load ? WaitExLoad : WaitExAlu;
      end
      if (mem_hit) begin
         return mem_load ? WaitMemLoad : WaitNone;
      end
      return WaitNone;
   endfunction

   function automatic logic [1:0] bht_next(logic [1:0] cnt, logic taken);
      if (taken) begin
         return (cnt == 2'b11) ? cnt : cnt + 2'b01;
      end
      return (cnt == 2'b00) ? cnt : cnt - 2'b01;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Decode-stage branch, forwarding-network and fetch-lookup signals of the branch resolver.
// The slave side is the resolver itself; the master side is the surrounding pipeline.
interface branch_resolve_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            flush;
   logic            br_valid;
   logic            is_jalr;
   logic [2:0]      br_func;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] imm;
   logic            pred_taken_dec;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [XLEN-1:0] rf_rdata1;
   logic [XLEN-1:0] rf_rdata2;
   logic [4:0]      ex_rd;
   logic            ex_wen;
   logic            ex_is_load;
   logic [4:0]      mem_rd;
   logic            mem_wen;
   logic            mem_is_load;
   logic [XLEN-1:0] mem_alu_out;
   logic [4:0]      wb_rd;
   logic            wb_wen;
   logic [XLEN-1:0] wb_data;
   logic [XLEN-1:0] if_pc;
   logic            if_pred_taken;
   logic            stall;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;

   modport slave (
      input  flush, br_valid, is_jalr, br_func, pc, imm, pred_taken_dec,
      input  rs1, rs2, rf_rdata1, rf_rdata2,
      input  ex_rd, ex_wen, ex_is_load,
      input  mem_rd, mem_wen, mem_is_load, mem_alu_out,
      input  wb_rd, wb_wen, wb_data,
      input  if_pc,
      output if_pred_taken, stall, redirect, redirect_pc
   );

   modport master (
      output flush, br_valid, is_jalr, br_func, pc, imm, pred_taken_dec,
      output rs1, rs2, rf_rdata1, rf_rdata2,
      output ex_rd, ex_wen, ex_is_load,
      output mem_rd, mem_wen, mem_is_load, mem_alu_out,
      output wb_rd, wb_wen, wb_data,
      output if_pc,
      input  if_pred_taken, stall, redirect, redirect_pc
   );

endinterface

// File: rtl/branch_compare.sv
// Combinational branch condition evaluator for the RISC-V conditional branch funct3 codes.
// Reserved funct3 values evaluate as not taken.
module branch_compare
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [2:0]      br_func,
   output logic            taken
);

   always_comb begin
      taken = 1'b0;
      case (br_func)
         FunctBeq:  taken = (op1 == op2);
         FunctBne:  taken = (op1 != op2);
         FunctBlt:  taken = ($signed(op1) < $signed(op2));
         FunctBge:  taken = ($signed(op1) >= $signed(op2));
         FunctBltu: taken = (op1 < op2);
         FunctBgeu: taken = (op1 >= op2);
         default:   taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves decode-stage branches and JALR with operand bypassing, hazard stalls and a 2-bit BHT.
// Redirects are issued combinationally in the cycle the branch resolves.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned BHT_ENTRIES = 64,
   parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES)
) (
   input logic                  clk,
   input logic                  rst,
   branch_resolve_unit_if.slave bus
);

   state_e          state_q, state_d;
   wait_t           wait_cnt_q, wait_cnt_d;
   logic [1:0]      bht_q [BHT_ENTRIES];

   logic            chk1, chk2;
   logic            ex_hit1, mem_hit1, wb_hit1;
   logic            ex_hit2, mem_hit2, wb_hit2;
   wait_t           wait1, wait2, wait_max;
   logic [XLEN-1:0] op1, op2;
   logic [XLEN-1:0] jalr_sum;
   logic            taken;

   logic            stall, redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            bht_upd;
   logic [IDX_W-1:0] bht_idx, if_idx;
   logic            unused_if_pc;

   // JALR ignores rs2, so only rs1 can create a hazard for it.
   assign chk1 = bus.br_valid;
   assign chk2 = bus.br_valid & ~bus.is_jalr;

   assign ex_hit1  = chk1 & producer_hit(bus.ex_rd, bus.ex_wen, bus.rs1);
   assign mem_hit1 = chk1 & producer_hit(bus.mem_rd, bus.mem_wen, bus.rs1);
   assign wb_hit1  = chk1 & producer_hit(bus.wb_rd, bus.wb_wen, bus.rs1);
   assign ex_hit2  = chk2 & producer_hit(bus.ex_rd, bus.ex_wen, bus.rs2);
   assign mem_hit2 = chk2 & producer_hit(bus.mem_rd, bus.mem_wen, bus.rs2);
   assign wb_hit2  = chk2 & producer_hit(bus.wb_rd, bus.wb_wen, bus.rs2);

   assign wait1    = operand_wait(ex_hit1, bus.ex_is_load, mem_hit1, bus.mem_is_load);
   assign wait2    = operand_wait(ex_hit2, bus.ex_is_load, mem_hit2, bus.mem_is_load);
   assign wait_max = (wait1 > wait2) ? wait1 : wait2;

   // An EX hit always stalls, so its value never needs a bypass path here.
   assign op1 = mem_hit1 ? bus.mem_alu_out :
                wb_hit1  ? bus.wb_data     : bus.rf_rdata1;
   assign op2 = mem_hit2 ? bus.mem_alu_out :
                wb_hit2  ? bus.wb_data     : bus.rf_rdata2;

   assign jalr_sum = op1 + bus.imm;

   branch_compare #(
      .XLEN (XLEN)
   ) u_branch_compare (
      .op1     (op1),
      .op2     (op2),
      .br_func (bus.br_func),
      .taken   (taken)
   );

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      bht_upd     = 1'b0;

      if (rst || bus.flush) begin
         state_d    = StEval;
         wait_cnt_d = WaitNone;
      end else begin
         unique case (state_q)
            StEval: begin
               if (bus.br_valid) begin
                  if (wait_max != WaitNone) begin
                     stall      = 1'b1;
                     wait_cnt_d = wait_max - 2'd1;
                     state_d    = (wait_cnt_d != WaitNone) ? StWait : StEval;
                  end else if (bus.is_jalr) begin
                     redirect    = 1'b1;
                     redirect_pc = {jalr_sum[XLEN-1:1], 1'b0};
                  end else begin
                     bht_upd = 1'b1;
                     if (taken != bus.pred_taken_dec) begin
                        redirect    = 1'b1;
                        redirect_pc = taken ? bus.pc + bus.imm : bus.pc + XLEN'(4);
                     end
                  end
               end
            end
            StWait: begin
               stall      = bus.br_valid;
               wait_cnt_d = wait_cnt_q - 2'd1;
               if (wait_cnt_d == WaitNone) begin
                  state_d = StEval;
               end
            end
            default: begin
               state_d    = StEval;
               wait_cnt_d = WaitNone;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StEval;
         wait_cnt_q <= WaitNone;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign bht_idx = bus.pc[IDX_W+1:2];
   assign if_idx  = bus.if_pc[IDX_W+1:2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= BhtReset;
         end
      end else if (bht_upd) begin
         bht_q[bht_idx] <= bht_next(bht_q[bht_idx], taken);
      end
   end

   // Lookup reads the registered array, so a same-cycle update is not visible yet.
   assign bus.if_pred_taken = bht_q[if_idx][1];
   assign bus.stall         = stall;
   assign bus.redirect      = redirect;
   assign bus.redirect_pc   = redirect_pc;

   assign unused_if_pc = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed scenarios with literal expectations, then random stimulus
// compared every cycle against a stage-priority behavioural model with a release-cycle stall.
module tb_branch_resolve_unit;

   localparam int XLEN    = 32;
   localparam int ENTRIES = 64;
   localparam int IW      = 6;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

   branch_resolve_unit #(
      .XLEN        (XLEN),
      .BHT_ENTRIES (ENTRIES),
      .IDX_W       (IW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int m_bht [ENTRIES];
   int m_cyc = 0;
   int m_release = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit hit(input logic [4:0] rd, input logic wen, input logic [4:0] src);
      return wen && rd != 0 && rd == src;
   endfunction

   // Cycles the decode stage must wait before this source can be bypassed.
   function automatic int src_wait(input logic [4:0] src, input bit used);
      if (!used) return 0;
      if (hit(bus.ex_rd, bus.ex_wen, src)) return bus.ex_is_load ? 2 : 1;
      if (hit(bus.mem_rd, bus.mem_wen, src)) return bus.mem_is_load ? 1 : 0;
      return 0;
   endfunction

   function automatic logic [31:0] src_val(input logic [4:0] src, input logic [31:0] rf);
      if (hit(bus.mem_rd, bus.mem_wen, src)) return bus.mem_alu_out;
      if (hit(bus.wb_rd, bus.wb_wen, src)) return bus.wb_data;
      return rf;
   endfunction

   function automatic bit cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 0;
      endcase
   endfunction

   task automatic model_check();
      logic        e_stall, e_red, e_pred, t;
      logic [31:0] e_pc, a, b;
      int          w, idx;
      e_stall = 0;
      e_red   = 0;
      e_pc    = 0;
      if (rst) begin
         foreach (m_bht[i]) m_bht[i] = 1;
         m_release = 0;
         e_pred    = 0;
      end else begin
         e_pred = (m_bht[int'(bus.if_pc[IW+1:2])] >= 2);
         if (bus.flush) begin
            m_release = m_cyc;
         end else if (bus.br_valid) begin
            if (m_cyc < m_release) begin
               e_stall = 1;
            end else begin
               w = src_wait(bus.rs1, 1);
               if (src_wait(bus.rs2, !bus.is_jalr) > w) w = src_wait(bus.rs2, !bus.is_jalr);
               if (w > 0) begin
                  e_stall   = 1;
                  m_release = m_cyc + w;
               end else begin
                  a = src_val(bus.rs1, bus.rf_rdata1);
                  b = src_val(bus.rs2, bus.rf_rdata2);
                  if (bus.is_jalr) begin
                     e_red = 1;
                     e_pc  = (a + bus.imm) & 32'hFFFF_FFFE;
                  end else begin
                     t     = cond(bus.br_func, a, b);
                     e_red = (t != bus.pred_taken_dec);
                     e_pc  = t ? bus.pc + bus.imm : bus.pc + 32'd4;
                     idx   = int'(bus.pc[IW+1:2]);
                     if (t && m_bht[idx] < 3) m_bht[idx]++;
                     if (!t && m_bht[idx] > 0) m_bht[idx]--;
                  end
               end
            end
         end
      end
      check("model_stall", {31'd0, bus.stall}, {31'd0, e_stall});
      check("model_redirect", {31'd0, bus.redirect}, {31'd0, e_red});
      check("model_if_pred_taken", {31'd0, bus.if_pred_taken}, {31'd0, e_pred});
      if (e_red || rst || !bus.br_valid) check("model_redirect_pc", bus.redirect_pc, e_red ? e_pc : 0);
      m_cyc++;
   endtask

   task automatic clear_inputs();
      bus.flush = 0; bus.br_valid = 0; bus.is_jalr = 0; bus.br_func = 0;
      bus.pc = 0; bus.imm = 0; bus.pred_taken_dec = 0;
      bus.rs1 = 0; bus.rs2 = 0; bus.rf_rdata1 = 0; bus.rf_rdata2 = 0;
      bus.ex_rd = 0; bus.ex_wen = 0; bus.ex_is_load = 0;
      bus.mem_rd = 0; bus.mem_wen = 0; bus.mem_is_load = 0; bus.mem_alu_out = 0;
      bus.wb_rd = 0; bus.wb_wen = 0; bus.wb_data = 0; bus.if_pc = 0;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic next_cycle();
      model_check();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rval();
      return ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
   endfunction

   task automatic rand_inputs();
      logic [2:0] funcs [6];
      funcs = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      rst                = ($urandom_range(0, 199) == 0);
      bus.flush          = ($urandom_range(0, 15) == 0);
      bus.br_valid       = ($urandom_range(0, 3) != 0) || (m_cyc < m_release);
      bus.is_jalr        = ($urandom_range(0, 4) == 0);
      bus.br_func        = funcs[$urandom_range(0, 5)];
      bus.pc             = $urandom;
      bus.imm            = $urandom;
      bus.pred_taken_dec = 1'($urandom_range(0, 1));
      bus.rs1            = 5'($urandom_range(0, 3));
      bus.rs2            = 5'($urandom_range(0, 3));
      bus.rf_rdata1      = rval();
      bus.rf_rdata2      = rval();
      bus.ex_rd          = 5'($urandom_range(0, 3));
      bus.ex_wen         = ($urandom_range(0, 2) == 0);
      bus.ex_is_load     = 1'($urandom_range(0, 1));
      bus.mem_rd         = 5'($urandom_range(0, 3));
      bus.mem_wen        = ($urandom_range(0, 2) == 0);
      bus.mem_is_load    = 1'($urandom_range(0, 1));
      bus.mem_alu_out    = rval();
      bus.wb_rd          = 5'($urandom_range(0, 3));
      bus.wb_wen         = 1'($urandom_range(0, 1));
      bus.wb_data        = rval();
      bus.if_pc          = {24'($urandom_range(0, 3)), 8'($urandom)};
   endtask

   initial begin
      logic exp_lookup [4];
      exp_lookup = '{1'b0, 1'b1, 1'b1, 1'b1};
      rst = 1;
      clear_inputs();
      // Hazardous branch during reset must stay quiet.
      bus.br_valid = 1; bus.rs1 = 3; bus.ex_rd = 3; bus.ex_wen = 1;
      settle();
      check("reset_stall", {31'd0, bus.stall}, 0);
      check("reset_redirect", {31'd0, bus.redirect}, 0);
      check("reset_redirect_pc", bus.redirect_pc, 0);
      next_cycle();
      rst = 0;
      clear_inputs();

      // BEQ equal operands, predicted not taken.
      bus.br_valid = 1; bus.br_func = 3'd0; bus.rs1 = 1; bus.rs2 = 2;
      bus.rf_rdata1 = 5; bus.rf_rdata2 = 5; bus.pc = 32'h100; bus.imm = 32'h40;
      bus.if_pc = 32'h100;
      settle();
      check("beq_stall", {31'd0, bus.stall}, 0);
      check("beq_redirect", {31'd0, bus.redirect}, 1);
      check("beq_target", bus.redirect_pc, 32'h140);
      check("beq_lookup_old", {31'd0, bus.if_pred_taken}, 0);
      next_cycle();
      clear_inputs(); bus.if_pc = 32'h100;
      settle();
      check("beq_bht_now_10", {31'd0, bus.if_pred_taken}, 1);
      check("idle_redirect_pc", bus.redirect_pc, 0);
      next_cycle();

      // BLT behind an EX load: two stall cycles, then resolve from wb_data.
      clear_inputs();
      bus.br_valid = 1; bus.br_func = 3'd4; bus.rs1 = 3; bus.rs2 = 4;
      bus.rf_rdata1 = 100; bus.rf_rdata2 = 2; bus.pc = 32'h200; bus.imm = 32'hFFFF_FFF0;
      bus.ex_rd = 3; bus.ex_wen = 1; bus.ex_is_load = 1;
      settle();
      check("blt_c0_stall", {31'd0, bus.stall}, 1);
      check("blt_c0_redirect", {31'd0, bus.redirect}, 0);
      next_cycle();
      bus.ex_wen = 0; bus.mem_rd = 3; bus.mem_wen = 1; bus.mem_is_load = 1;
      settle();
      check("blt_c1_stall", {31'd0, bus.stall}, 1);
      next_cycle();
      bus.mem_wen = 0; bus.wb_rd = 3; bus.wb_wen = 1; bus.wb_data = 32'hFFFF_FFFB;
      settle();
      check("blt_c2_stall", {31'd0, bus.stall}, 0);
      check("blt_c2_redirect", {31'd0, bus.redirect}, 1);
      check("blt_c2_target", bus.redirect_pc, 32'h1F0);
      next_cycle();

      // JALR from MEM ALU bypass; EX hit on rs2 must be ignored.
      clear_inputs();
      bus.br_valid = 1; bus.is_jalr = 1; bus.br_func = 3'd5; bus.rs1 = 5; bus.rs2 = 6;
      bus.ex_rd = 6; bus.ex_wen = 1; bus.mem_rd = 5; bus.mem_wen = 1;
      bus.mem_alu_out = 32'h1001; bus.rf_rdata1 = 32'h5000; bus.imm = 4; bus.pc = 32'h408;
      settle();
      check("jalr_stall", {31'd0, bus.stall}, 0);
      check("jalr_redirect", {31'd0, bus.redirect}, 1);
      check("jalr_target", bus.redirect_pc, 32'h1004);
      next_cycle();

      // BNE: EX ALU on rs2 and MEM load on rs1 give a single stall cycle.
      clear_inputs();
      bus.br_valid = 1; bus.br_func = 3'd1; bus.rs1 = 7; bus.rs2 = 8;
      bus.ex_rd = 8; bus.ex_wen = 1; bus.mem_rd = 7; bus.mem_wen = 1; bus.mem_is_load = 1;
      bus.pc = 32'h300; bus.imm = 32'h80; bus.pred_taken_dec = 1;
      bus.rf_rdata1 = 1; bus.rf_rdata2 = 2;
      settle();
      check("bne_c0_stall", {31'd0, bus.stall}, 1);
      next_cycle();
      bus.ex_wen = 0; bus.mem_rd = 8; bus.mem_is_load = 0; bus.mem_alu_out = 10;
      bus.wb_rd = 7; bus.wb_wen = 1; bus.wb_data = 10;
      settle();
      check("bne_c1_stall", {31'd0, bus.stall}, 0);
      check("bne_c1_redirect", {31'd0, bus.redirect}, 1);
      check("bne_c1_target", bus.redirect_pc, 32'h304);
      next_cycle();

      // Flush in the middle of a two-cycle stall.
      clear_inputs();
      bus.br_valid = 1; bus.br_func = 3'd1; bus.rs1 = 7; bus.rs2 = 8;
      bus.ex_rd = 7; bus.ex_wen = 1; bus.ex_is_load = 1; bus.pc = 32'h300;
      bus.pred_taken_dec = 1; bus.rf_rdata1 = 1; bus.rf_rdata2 = 2;
      settle();
      check("flush_c0_stall", {31'd0, bus.stall}, 1);
      next_cycle();
      bus.flush = 1;
      settle();
      check("flush_c1_stall", {31'd0, bus.stall}, 0);
      check("flush_c1_redirect", {31'd0, bus.redirect}, 0);
      next_cycle();
      bus.flush = 0; bus.ex_wen = 0;
      settle();
      check("flush_c2_stall", {31'd0, bus.stall}, 0);
      check("flush_c2_redirect", {31'd0, bus.redirect}, 0);
      next_cycle();

      // Four taken updates to one entry while looking it up in the same cycle.
      clear_inputs();
      bus.br_valid = 1; bus.br_func = 3'd0; bus.rs1 = 9; bus.rs2 = 10;
      bus.rf_rdata1 = 3; bus.rf_rdata2 = 3; bus.pc = 32'h44; bus.pred_taken_dec = 1;
      bus.if_pc = 32'h44;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("bht_sat_lookup", {31'd0, bus.if_pred_taken}, {31'd0, exp_lookup[i]});
         next_cycle();
      end
      clear_inputs(); bus.if_pc = 32'h44;
      settle();
      check("bht_sat_hold_11", {31'd0, bus.if_pred_taken}, 1);
      next_cycle();

      // Reset while in the wait state.
      clear_inputs();
      bus.br_valid = 1; bus.br_func = 3'd0; bus.rs1 = 3; bus.ex_rd = 3; bus.ex_wen = 1;
      bus.ex_is_load = 1; bus.pc = 32'h500;
      settle();
      check("rst_wait_c0_stall", {31'd0, bus.stall}, 1);
      next_cycle();
      rst = 1;
      #1;
      check("rst_async_stall", {31'd0, bus.stall}, 0);
      check("rst_async_redirect", {31'd0, bus.redirect}, 0);
      #3;
      next_cycle();
      rst = 0;
      clear_inputs();
      for (int i = 0; i < ENTRIES; i++) begin
         bus.if_pc = 32'(i) << 2;
         settle();
         check("rst_bht_entry", {31'd0, bus.if_pred_taken}, 0);
         next_cycle();
      end

      repeat (3000) begin
         rand_inputs();
         settle();
         next_cycle();
      end
      rst = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
